// File: rtl/stopwatch_mux_n.sv
// N-digit BCD stopwatch with run/stop, lap freeze, clear, wrap/saturate overflow and a scanned 7-segment driver.
// Count and flags update on the edge after an event; segment pins are registered one cycle behind the scan index.
module stopwatch_mux_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int DP_POS   = 2,
  parameter int WRAP     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_stop_i,
  input  logic                  lap_i,
  input  logic                  clear_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            bcd_o,
  output logic                  dp_o,
  output logic                  overflow_o,
  output logic                  running_o,
  output logic [4*DIGITS-1:0]   count_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [31:0] DP_U = DP_POS;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic [4*DIGITS-1:0]  snap_q, snap_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 ovf_q, ovf_d;
  logic [SW-1:0]        scan_q;
  logic [IW-1:0]        idx_q;
  logic [DIGITS-1:0]    an_q;
  logic [6:0]           bcd_q;
  logic                 dp_q;

  logic [4*DIGITS-1:0]  inc_cnt;
  logic                 carry;
  logic                 all9;
  logic [4*DIGITS-1:0]  disp;
  logic [3:0]           cur_dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Ripple-carry BCD increment; a carry out of the top digit means all-9.
  always_comb begin
    carry   = 1'b1;
    inc_cnt = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_cnt[4*i +: 4] = 4'd0;
        end else begin
          inc_cnt[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all9 = carry;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    snap_d  = snap_q;
    presc_d = presc_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_STOPPED: begin
        if (clear_i) begin
          count_d = '0;
          presc_d = '0;
          ovf_d   = 1'b0;
        end else if (start_stop_i) begin
          state_d = ST_RUNNING;
          presc_d = '0;
        end
      end
      ST_RUNNING: begin
        if (start_stop_i) begin
          state_d = ST_STOPPED;
        end else if (lap_i) begin
          state_d = ST_LAP;
          snap_d  = count_q;
        end
      end
      ST_LAP: begin
        if (start_stop_i) begin
          state_d = ST_STOPPED;
        end else if (lap_i) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    // Timebase keeps going in the cycle a stop is registered; saturation overrides any event.
    if (state_q == ST_RUNNING || state_q == ST_LAP) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (all9) begin
          ovf_d = 1'b1;
          if (WRAP != 0) begin
            count_d = inc_cnt;
          end else begin
            state_d = ST_STOPPED;
          end
        end else begin
          count_d = inc_cnt;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STOPPED;
      count_q <= '0;
      snap_q  <= '0;
      presc_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign disp = (state_q == ST_LAP) ? snap_q : count_q;

  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_dig = disp[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      bcd_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      an_q  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
      bcd_q <= seg7(cur_dig);
      dp_q  <= (32'(idx_q) != DP_U);
    end
  end

  assign an_o       = an_q;
  assign bcd_o      = bcd_q;
  assign dp_o       = dp_q;
  assign overflow_o = ovf_q;
  assign running_o  = (state_q != ST_STOPPED);
  assign count_o    = count_q;

endmodule

// File: tb/tb_stopwatch_mux_n.sv
// Drives a wrapping and a saturating stopwatch with identical stimulus and compares both against a decimal reference model.
module tb_stopwatch_mux_n;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int DP_POS   = 2;
  localparam int MAXV     = 9999;

  logic clk = 1'b0;
  logic rst_i = 1'b1, start_stop_i = 1'b0, lap_i = 1'b0, clear_i = 1'b0;

  logic [3:0]  an_w, an_s;
  logic [6:0]  bcd_w, bcd_s;
  logic        dp_w, dp_s, ovf_w, ovf_s, run_w, run_s;
  logic [15:0] cnt_w, cnt_s;

  always #5 clk = ~clk;

  stopwatch_mux_n #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                    .DP_POS(DP_POS), .WRAP(1)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .start_stop_i(start_stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .an_o(an_w), .bcd_o(bcd_w), .dp_o(dp_w),
    .overflow_o(ovf_w), .running_o(run_w), .count_o(cnt_w));

  stopwatch_mux_n #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                    .DP_POS(DP_POS), .WRAP(0)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .start_stop_i(start_stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .an_o(an_s), .bcd_o(bcd_s), .dp_o(dp_s),
    .overflow_o(ovf_s), .running_o(run_s), .count_o(cnt_s));

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model, index 0 = wrapping instance, 1 = saturating instance.
  int  m_cnt [2];
  int  m_presc [2];
  int  m_snap [2];
  bit  m_ovf [2];
  bit  m_run [2];
  bit  m_lap [2];
  int  m_edges;
  logic [3:0] e_an [2];
  logic [6:0] e_bcd [2];
  logic       e_dp [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_edge(input int k, input bit ss, input bit lp, input bit cl,
                            input bit rs, input int edges_before);
    int shown;
    int idx;
    int pw;
    if (rs) begin
      m_cnt[k] = 0; m_presc[k] = 0; m_snap[k] = 0;
      m_ovf[k] = 0; m_run[k] = 0; m_lap[k] = 0;
      e_an[k] = 4'hF; e_bcd[k] = 7'h7F; e_dp[k] = 1'b1;
      return;
    end
    shown = m_lap[k] ? m_snap[k] : m_cnt[k];
    idx = (edges_before / SCAN_DIV) % DIGITS;
    pw = 1;
    for (int j = 0; j < idx; j++) pw = pw * 10;
    e_an[k]  = ~(4'(1) << idx);
    e_bcd[k] = seg_tab[(shown / pw) % 10];
    e_dp[k]  = (idx != DP_POS);
    if (!m_run[k]) begin
      if (cl) begin
        m_cnt[k] = 0; m_presc[k] = 0; m_ovf[k] = 0;
      end else if (ss) begin
        m_run[k] = 1; m_presc[k] = 0;
      end
    end else begin
      int cnt_before;
      cnt_before = m_cnt[k];
      if (ss) begin
        m_run[k] = 0; m_lap[k] = 0;
      end else if (lp) begin
        if (m_lap[k]) m_lap[k] = 0;
        else begin m_lap[k] = 1; m_snap[k] = cnt_before; end
      end
      if (m_presc[k] == TICK_DIV - 1) begin
        m_presc[k] = 0;
        if (cnt_before == MAXV) begin
          m_ovf[k] = 1;
          if (k == 0) m_cnt[k] = 0;
          else begin m_run[k] = 0; m_lap[k] = 0; end
        end else begin
          m_cnt[k] = cnt_before + 1;
        end
      end else begin
        m_presc[k] = m_presc[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("wrap.count",   32'(cnt_w), 32'(to_bcd(m_cnt[0])));
    check("wrap.running", 32'(run_w), 32'(m_run[0]));
    check("wrap.ovf",     32'(ovf_w), 32'(m_ovf[0]));
    check("wrap.an",      32'(an_w),  32'(e_an[0]));
    check("wrap.bcd",     32'(bcd_w), 32'(e_bcd[0]));
    check("wrap.dp",      32'(dp_w),  32'(e_dp[0]));
    check("sat.count",    32'(cnt_s), 32'(to_bcd(m_cnt[1])));
    check("sat.running",  32'(run_s), 32'(m_run[1]));
    check("sat.ovf",      32'(ovf_s), 32'(m_ovf[1]));
    check("sat.an",       32'(an_s),  32'(e_an[1]));
    check("sat.bcd",      32'(bcd_s), 32'(e_bcd[1]));
    check("sat.dp",       32'(dp_s),  32'(e_dp[1]));
  endtask

  // One clock edge: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic step(input bit ss, input bit lp, input bit cl, input bit rs);
    int eb;
    start_stop_i = ss; lap_i = lp; clear_i = cl; rst_i = rs;
    @(posedge clk);
    eb = m_edges;
    for (int k = 0; k < 2; k++) model_edge(k, ss, lp, cl, rs, eb);
    m_edges = rs ? 0 : m_edges + 1;
    @(negedge clk);
    start_stop_i = 0; lap_i = 0; clear_i = 0; rst_i = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_until(input int target, input int budget);
    int c;
    c = 0;
    while (m_cnt[0] != target && c < budget) begin
      step(0, 0, 0, 0);
      c++;
    end
    check("run_until.reached", 32'(m_cnt[0]), 32'(target));
  endtask

  initial begin
    m_edges = 0;
    @(negedge clk);
    step(0, 0, 0, 1);
    idle(3);

    // Start timing and first ticks
    step(1, 0, 0, 0);
    check("t1.running_after_start", 32'(run_w), 32'd1);
    idle(3);
    check("t1.count_before_tick", 32'(cnt_w), 32'h0000);
    step(0, 0, 0, 0);
    check("t1.first_tick", 32'(cnt_w), 32'h0001);
    idle(4);
    check("t1.second_tick", 32'(cnt_w), 32'h0002);
    check("t1.no_ovf", 32'(ovf_w), 32'd0);

    // Carry, stop, clear
    run_until(10, 200);
    check("t2.carry", 32'(cnt_w), 32'h0010);
    step(1, 0, 0, 0);
    idle(10);
    check("t2.frozen", 32'(cnt_w), 32'h0010);
    step(0, 0, 1, 0);
    check("t2.cleared", 32'(cnt_w), 32'h0000);
    step(1, 0, 0, 0);
    idle(20);

    // Lap freeze and release
    run_until(12, 200);
    step(0, 1, 0, 0);
    run_until(15, 200);
    idle(2);
    step(0, 1, 0, 0);
    idle(12);

    // Simultaneous events and mid-run reset
    step(1, 1, 0, 0);
    check("t6.stop_beats_lap", 32'(run_w), 32'd0);
    step(1, 0, 1, 0);
    check("t6.clear_beats_start_run", 32'(run_w), 32'd0);
    check("t6.clear_beats_start_cnt", 32'(cnt_w), 32'h0000);
    step(1, 0, 0, 0);
    idle(13);
    step(0, 0, 0, 1);
    check("t6.reset_an", 32'(an_w), 32'hF);
    check("t6.reset_bcd", 32'(bcd_w), 32'h7F);

    // Randomised pulses
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 999) == 0);
    end

    // Overflow: wrapping keeps running, saturating stops at all-9
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    begin
      int c;
      c = 0;
      while (!m_ovf[0] && c < 40100) begin
        step(0, 0, 0, 0);
        c++;
      end
    end
    check("t4.wrap_count", 32'(cnt_w), 32'h0000);
    check("t4.wrap_ovf", 32'(ovf_w), 32'd1);
    check("t4.wrap_running", 32'(run_w), 32'd1);
    check("t4.sat_count", 32'(cnt_s), 32'h9999);
    check("t4.sat_ovf", 32'(ovf_s), 32'd1);
    check("t4.sat_running", 32'(run_s), 32'd0);
    idle(40);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
